// File: rtl/edge_digit_counter.sv
// Run/pause/clear event counter with a synchronised count input and per-digit readout for a scanned display.
// Define EDGE_DIGIT_COUNTER_BOTH_EDGE_EN to count both edges of signal instead of rising edges only.
module edge_digit_counter #(
   parameter  int NDIG      = 2,
   parameter  int RADIX     = 10,
   parameter  int MAX_COUNT = 20,
   localparam int CNT_W     = $clog2(MAX_COUNT + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             clr,
   input  logic             up_dn,
   input  logic             signal,
   input  logic [NDIG-1:0]  dig_sel_n,
   output logic [3:0]       num,
   output logic [CNT_W-1:0] cnt,
   output logic             wrap,
   output logic             running
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_COUNT);
   localparam int unsigned      RADIX_U = RADIX;

   state_t           state, state_nxt;
   logic             s0, s1, s2;
   logic             evt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             wrap_nxt;
   logic [3:0]       digit [NDIG];

   // s0/s1 resynchronise the asynchronous input; s2 holds the previous synchronised level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0 <= 1'b0;
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s0 <= signal;
         s1 <= s0;
         s2 <= s1;
      end
   end

`ifdef EDGE_DIGIT_COUNTER_BOTH_EDGE_EN
   assign evt = s1 ^ s2;
`else
   assign evt = s1 & ~s2;
`endif

   always_comb begin
      state_nxt = state;
      if (clr) begin
         state_nxt = IDLE;
      end else if (stop) begin
         if (state == RUN) state_nxt = PAUSE;
      end else if (start) begin
         if (state != RUN) state_nxt = RUN;
      end
   end

   // Events outside RUN are dropped; clr overrides any concurrent event.
   always_comb begin
      cnt_nxt  = cnt;
      wrap_nxt = 1'b0;
      if (clr) begin
         cnt_nxt = '0;
      end else if (evt && state == RUN) begin
         if (up_dn) begin
            if (cnt == MAX_C) begin
               cnt_nxt  = '0;
               wrap_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end else begin
            if (cnt == '0) begin
               cnt_nxt  = MAX_C;
               wrap_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         wrap  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         wrap  <= wrap_nxt;
      end
   end

   for (genvar i = 0; i < NDIG; i++) begin : g_digit
      localparam int unsigned DIV = RADIX_U ** i;
      assign digit[i] = 4'((32'(cnt) / DIV) % RADIX_U);
   end

   // Walking from the top index down lets the lowest selected digit win.
   always_comb begin
      num = 4'd0;
      for (int i = NDIG - 1; i >= 0; i--) begin
         if (!dig_sel_n[i]) num = digit[i];
      end
   end

   assign running = (state == RUN);

endmodule

// File: tb/tb_edge_digit_counter.sv
// Testbench for edge_digit_counter: vector table, corner-case sequences and a randomized run against a reference model.
module tb_edge_digit_counter;

   localparam int MAXC = 20;
`ifdef EDGE_DIGIT_COUNTER_BOTH_EDGE_EN
   localparam int EPP = 2;
`else
   localparam int EPP = 1;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, stop = 1'b0, clr = 1'b0, up_dn = 1'b1, signal = 1'b0;
   logic [1:0] dig_sel_n = 2'b11;
   logic [3:0] num10, num16;
   logic [4:0] cnt10, cnt16;
   logic       wrap10, wrap16, run10, run16;

   always #5 clk = ~clk;

   edge_digit_counter #(.NDIG(2), .RADIX(10), .MAX_COUNT(MAXC)) dut10 (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clr(clr), .up_dn(up_dn),
      .signal(signal), .dig_sel_n(dig_sel_n), .num(num10), .cnt(cnt10), .wrap(wrap10),
      .running(run10));

   edge_digit_counter #(.NDIG(2), .RADIX(16), .MAX_COUNT(MAXC)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clr(clr), .up_dn(up_dn),
      .signal(signal), .dig_sel_n(dig_sel_n), .num(num16), .cnt(cnt16), .wrap(wrap16),
      .running(run16));

   int checks = 0, passes = 0, wrap_seen = 0;

   always @(negedge clk) if (wrap10 === 1'b1) wrap_seen++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
      else passes++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int n);
      repeat (n) begin
         signal = 1'b1;
         repeat (4) tick();
         signal = 1'b0;
         repeat (4) tick();
      end
   endtask

   task automatic ctl(input bit s, input bit p, input bit c);
      start = s; stop = p; clr = c;
      tick();
      start = 1'b0; stop = 1'b0; clr = 1'b0;
   endtask

   // Reference model: mode 0=idle, 1=running, 2=paused.
   int m_mode = 0, m_cnt = 0, m_wraps = 0;

   function automatic void m_ctl(input bit s, input bit p, input bit c);
      if (c) begin
         m_mode = 0;
         m_cnt  = 0;
      end else if (p) begin
         if (m_mode == 1) m_mode = 2;
      end else if (s) begin
         m_mode = 1;
      end
   endfunction

   function automatic void m_events(input int n, input bit up);
      for (int k = 0; k < n; k++) begin
         if (m_mode == 1) begin
            if (up) begin
               if (m_cnt == MAXC) begin m_cnt = 0; m_wraps++; end
               else m_cnt++;
            end else begin
               if (m_cnt == 0) begin m_cnt = MAXC; m_wraps++; end
               else m_cnt--;
            end
         end
      end
   endfunction

   function automatic int m_num(input logic [1:0] sel);
      if (!sel[0]) return m_cnt % 10;
      if (!sel[1]) return (m_cnt / 10) % 10;
      return 0;
   endfunction

   typedef struct {
      bit s; bit p; bit c; bit up;
      int np;
      int exp_cnt;
      bit exp_run;
   } vec_t;

   vec_t tbl [8];

   initial begin
      tbl[0] = '{1, 0, 0, 1, 0, 0, 1};
      tbl[1] = '{0, 0, 0, 1, 5, 5 * EPP, 1};
      tbl[2] = '{1, 1, 0, 1, 3, 5 * EPP, 0};
      tbl[3] = '{1, 0, 0, 1, 2, 7 * EPP, 1};
      tbl[4] = '{0, 0, 0, 0, 3, 4 * EPP, 1};
      tbl[5] = '{0, 0, 1, 1, 2, 0, 0};
      tbl[6] = '{1, 0, 0, 0, 1, 21 - EPP, 1};
      tbl[7] = '{0, 0, 0, 1, 1, 0, 1};

      // reset state, checked while reset is held
      #12;
      chk("rst_cnt", cnt10, 0);
      chk("rst_wrap", wrap10, 0);
      chk("rst_running", run10, 0);
      dig_sel_n = 2'b10;
      #1;
      chk("rst_num", num10, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // vector table
      wrap_seen = 0;
      for (int i = 0; i < 8; i++) begin
         ctl(tbl[i].s, tbl[i].p, tbl[i].c);
         up_dn = tbl[i].up;
         pulse(tbl[i].np);
         chk($sformatf("tbl%0d_cnt", i), cnt10, tbl[i].exp_cnt);
         chk($sformatf("tbl%0d_running", i), run10, tbl[i].exp_run);
      end
      chk("tbl_wrap_total", wrap_seen, 2);

      // event-to-count latency and digit selection
      ctl(0, 0, 1);
      ctl(1, 0, 0);
      up_dn  = 1'b1;
      signal = 1'b1;
      tick(); tick();
      chk("latency_2cyc", cnt10, 0);
      tick();
      chk("latency_3cyc", cnt10, 1);
      repeat (3) tick();
      signal = 1'b0;
      repeat (4) tick();
      pulse(4);
      chk("five_pulses_cnt", cnt10, 5 * EPP);
      dig_sel_n = 2'b10; #1;
      chk("num_sel10", num10, (5 * EPP) % 10);
      dig_sel_n = 2'b01; #1;
      chk("num_sel01", num10, (5 * EPP) / 10);
      dig_sel_n = 2'b00; #1;
      chk("num_sel00", num10, (5 * EPP) % 10);
      dig_sel_n = 2'b11; #1;
      chk("num_sel11", num10, 0);

      // terminal wrap going up: one-cycle pulse
      ctl(0, 0, 1);
      ctl(1, 0, 0);
      pulse(20 / EPP);
      chk("preload_20", cnt10, 20);
      wrap_seen = 0;
      signal = 1'b1;
      tick(); tick();
      chk("wrap_before", wrap10, 0);
      tick();
      chk("wrap_up_cnt", cnt10, 0);
      chk("wrap_up_high", wrap10, 1);
      tick();
      chk("wrap_up_low", wrap10, 0);
      chk("wrap_up_once", wrap_seen, 1);
      signal = 1'b0;
      repeat (4) tick();

      // wrap going down, radix 10 and 16 digits
      ctl(0, 0, 1);
      ctl(1, 0, 0);
      up_dn  = 1'b0;
      signal = 1'b1;
      repeat (3) tick();
      chk("wrap_dn_cnt", cnt10, 20);
      chk("wrap_dn_high", wrap10, 1);
      chk("hex_cnt", cnt16, 20);
      dig_sel_n = 2'b10; #1;
      chk("hex_digit0", num16, 4);
      chk("dec_digit0", num10, 0);
      dig_sel_n = 2'b01; #1;
      chk("hex_digit1", num16, 1);
      chk("dec_digit1", num10, 2);
      signal = 1'b0;
      repeat (4) tick();

      // clr coincident with an event at cnt=7
      ctl(0, 0, 1);
      ctl(1, 0, 0);
      up_dn = 1'b1;
      pulse(7 / EPP);
      if (EPP == 2) begin
         signal = 1'b1;
         repeat (4) tick();
      end
      chk("pre_clr_cnt", cnt10, 7);
      wrap_seen = 0;
      signal = ~signal;
      tick(); tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_evt_cnt", cnt10, 0);
      chk("clr_evt_wrap", wrap10, 0);
      chk("clr_evt_running", run10, 0);
      signal = 1'b0;
      repeat (4) tick();
      chk("clr_evt_idle_cnt", cnt10, 0);
      chk("clr_evt_no_wrap", wrap_seen, 0);

      // reset with an event in flight
      ctl(1, 0, 0);
      pulse(1);
      chk("pre_rst_cnt", cnt10, EPP);
      signal = 1'b1;
      tick(); tick();
      rst_n = 1'b0;
      #2;
      chk("async_rst_cnt", cnt10, 0);
      chk("async_rst_running", run10, 0);
      tick();
      rst_n  = 1'b1;
      signal = 1'b0;
      repeat (4) tick();
      ctl(1, 0, 0);
      repeat (4) tick();
      chk("post_rst_cnt", cnt10, 0);
      pulse(1);
      chk("post_rst_fresh", cnt10, EPP);

      // randomized run against the model
      ctl(0, 0, 1);
      m_ctl(0, 0, 1);
      wrap_seen = 0;
      m_wraps   = 0;
      for (int i = 0; i < 40; i++) begin
         bit s, p, c;
         int n;
         s = 1'($urandom_range(0, 1));
         p = ($urandom_range(0, 3) == 0);
         c = ($urandom_range(0, 9) == 0);
         ctl(s, p, c);
         m_ctl(s, p, c);
         up_dn = 1'($urandom_range(0, 1));
         n = $urandom_range(0, 3);
         pulse(n);
         m_events(n * EPP, up_dn);
         dig_sel_n = 2'($urandom_range(0, 3));
         #1;
         chk($sformatf("rnd%0d_cnt", i), cnt10, m_cnt);
         chk($sformatf("rnd%0d_running", i), run10, (m_mode == 1));
         chk($sformatf("rnd%0d_num", i), num10, m_num(dig_sel_n));
      end
      chk("rnd_wrap_total", wrap_seen, m_wraps);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
